multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multi-cycle LEGv8 core. Sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It produces the 2-bit ALU_Op consumed by the ALU control stage, and handshakes with a variable-latency unified memory.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  11  instruction bits [31:21], taken from the instruction register.
- Zero  in  1  ALU zero flag.
- Mem_Ready  in  1  memory access completes this cycle.
- PC_Write  out  1  PC register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- Mem_Read  out  1  memory read request.
- Mem_Write  out  1  memory write request.
- IR_Write  out  1  load the IR, and load Old_PC with the current PC.
- Reg2Loc  out  1  register read port 2 address: 0 = Rm, 1 = Rt.
- ALU_Src_A  out  1  ALU operand A: 0 = Old_PC / PC, 1 = register A.
- ALU_Src_B  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- ALU_Op  out  2  00 = add, 01 = pass B, 10 = decode from opcode field.
- PC_Source  out  1  PC input: 0 = ALU result, 1 = ALUOut.
- Mem_to_Reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- Reg_Write  out  1  register file write enable.
- Illegal  out  1  sticky flag: an unsupported opcode was decoded.
- Instr_Retired  out  1  one-cycle pulse on each instruction's final cycle.

## Operation
- Instruction classes, decided from Opcode:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR: 11111000010.
  - STUR: 11111000000.
  - CBZ: Opcode[10:3] = 10110100.
  - B: Opcode[10:5] = 000101.
  - Anything else is illegal.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, CBRANCH, JUMP, HALT.
- FETCH:
  - Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=00, PC_Source=0.
  - IR_Write and PC_Write assert only in a cycle where Mem_Ready=1; the FSM then moves to DECODE. Otherwise it holds FETCH.
- DECODE: ALU_Src_A=0 (selects Old_PC), ALU_Src_B=11, ALU_Op=00, so the branch target is latched into ALUOut. Next state by class:
  - LDUR/STUR → MEM_ADDR.
  - R-type → R_EXEC.
  - CBZ → CBRANCH.
  - B → JUMP.
  - Illegal → HALT.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00. Next state is MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: Mem_Read=1, IorD=1; holds until Mem_Ready=1, then → MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=1, Instr_Retired=1, → FETCH.
- MEM_WR: Mem_Write=1, IorD=1, Reg2Loc=1. Holds until Mem_Ready=1; in that cycle Instr_Retired=1 and → FETCH.
- R_EXEC: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=10, Reg2Loc=0, → R_WB.
- R_WB: Reg_Write=1, Mem_to_Reg=0, Instr_Retired=1, → FETCH.
- CBRANCH: Reg2Loc=1, ALU_Src_B=00, ALU_Op=01, PC_Source=1, PC_Write=Zero, Instr_Retired=1, → FETCH.
- JUMP: PC_Source=1, PC_Write=1, Instr_Retired=1, → FETCH.
- HALT: Illegal=1, all enables 0; terminal until reset.
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore from the state register, with these Mealy exceptions:
  - IR_Write and PC_Write in FETCH, gated by Mem_Ready.
  - PC_Write in CBRANCH, gated by Zero.
  - Instr_Retired in MEM_WR, gated by Mem_Ready.
- Cycle counts with Mem_Ready tied high: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- Each cycle Mem_Ready is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- While rst_n is low, all outputs are 0 and the state is FETCH. The first FETCH request appears in the first cycle after rst_n rises.
- Reset asserted mid-access abandons the access. No write or retire pulse is generated.
- Mem_Ready high in states that do not access memory is ignored.

## Configuration
- CBNZ_EN defined:
  - Opcode[10:3] = 10110101 (CBNZ) is legal and follows the CBRANCH path, with PC_Write = !Zero.
  - A registered flag captured in DECODE selects the Zero polarity.
- CBNZ_EN undefined: CBNZ decodes as illegal → HALT.

## Structure
- Shared package holds:
  - Opcode and opcode-prefix constants.
  - State enum.
  - ALU_Op encodings (ADD, PASS_B, FUNCT).
  - ALU_Src_B encodings.
- Sub-module instr_class_decode: purely combinational, Opcode → class (RTYPE, LOAD, STORE, CBZ, CBNZ, BR, ILL). It is instantiated once, by the FSM.

## Test plan
- ADD opcode 10001011000, Mem_Ready=1:
  - Visits FETCH, DECODE, R_EXEC, R_WB.
  - ALU_Op=10 in R_EXEC.
  - Reg_Write=1 and Instr_Retired=1 on cycle 4.
- LDUR 11111000010 with Mem_Ready low for 2 cycles in MEM_RD → 7 cycles total; Mem_to_Reg=1 with Reg_Write in MEM_WB.
- CBZ with Zero=1 → PC_Write=1 and PC_Source=1 in CBRANCH. Repeat with Zero=0 → PC_Write=0, Instr_Retired still 1.
- Opcode 00000000000 → HALT:
  - Illegal=1 and stays 1 for 20 cycles, with no enables.
  - rst_n pulse clears Illegal and restarts in FETCH.
- rst_n asserted during MEM_WR with Mem_Ready=0:
  - Mem_Write drops immediately, asynchronously.
  - After release, the first cycle is FETCH with Mem_Read=1.
- CBNZ 10110101:
  - With CBNZ_EN: Zero=0 → PC_Write=1.
  - Without CBNZ_EN: → HALT.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle LEGv8 main control FSM:
// opcode constants, state and instruction-class enums, ALU select encodings.
package multicycle_control_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Branch opcodes are matched on their prefix only; the low bits carry immediate.
  localparam logic [7:0] PFX_CBZ  = 8'b10110100;
  localparam logic [7:0] PFX_CBNZ = 8'b10110101;
  localparam logic [5:0] PFX_B    = 6'b000101;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_R_EXEC,
    ST_R_WB,
    ST_CBRANCH,
    ST_JUMP,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_PASS_B = 2'b01,
    ALU_OP_FUNCT  = 2'b10
  } alu_op_t;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_CBZ,
    CLS_CBNZ,
    CLS_BR,
    CLS_ILL
  } instr_class_t;

endpackage

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational opcode classifier feeding the main control FSM.
module instr_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0]  opcode,
  output instr_class_t instr_class
);

  always_comb begin
    instr_class = CLS_ILL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      instr_class = CLS_RTYPE;
    else if (opcode == OP_LDUR)
      instr_class = CLS_LOAD;
    else if (opcode == OP_STUR)
      instr_class = CLS_STORE;
    else if (opcode[10:3] == PFX_CBZ)
      instr_class = CLS_CBZ;
    else if (opcode[10:3] == PFX_CBNZ)
      instr_class = CLS_CBNZ;
    else if (opcode[10:5] == PFX_B)
      instr_class = CLS_BR;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle LEGv8 core (fetch/decode/execute/mem/wb).
// Optional macro CBNZ_EN: accept CBNZ and branch on a non-zero register.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        PC_Write,
  output logic        IorD,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        IR_Write,
  output logic        Reg2Loc,
  output logic        ALU_Src_A,
  output logic [1:0]  ALU_Src_B,
  output logic [1:0]  ALU_Op,
  output logic        PC_Source,
  output logic        Mem_to_Reg,
  output logic        Reg_Write,
  output logic        Illegal,
  output logic        Instr_Retired
);

  state_t       state_q;
  state_t       state_d;
  instr_class_t instr_class;
  alu_op_t      alu_op;
  logic         take_branch;

  instr_class_decode u_decode (
    .opcode      (Opcode),
    .instr_class (instr_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

`ifdef CBNZ_EN
  // Polarity is latched in DECODE so CBRANCH does not depend on the IR staying put.
  logic cbnz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cbnz_q <= 1'b0;
    else if (state_q == ST_DECODE)  cbnz_q <= (instr_class == CLS_CBNZ);
  end

  assign take_branch = cbnz_q ? ~Zero : Zero;
`else
  assign take_branch = Zero;
`endif

  assign ALU_Op = alu_op;

  // Outputs are forced low while rst_n is low even though the state already reads FETCH.
  always_comb begin
    state_d       = state_q;
    PC_Write      = 1'b0;
    IorD          = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    IR_Write      = 1'b0;
    Reg2Loc       = 1'b0;
    ALU_Src_A     = 1'b0;
    ALU_Src_B     = SRC_B_REG;
    alu_op        = ALU_OP_ADD;
    PC_Source     = 1'b0;
    Mem_to_Reg    = 1'b0;
    Reg_Write     = 1'b0;
    Illegal       = 1'b0;
    Instr_Retired = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_FETCH: begin
          Mem_Read  = 1'b1;
          ALU_Src_B = SRC_B_FOUR;
          IR_Write  = Mem_Ready;
          PC_Write  = Mem_Ready;
          if (Mem_Ready) state_d = ST_DECODE;
        end
        ST_DECODE: begin
          ALU_Src_B = SRC_B_IMM_SH2;
          case (instr_class)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM_ADDR;
            CLS_RTYPE:           state_d = ST_R_EXEC;
            CLS_CBZ:             state_d = ST_CBRANCH;
`ifdef CBNZ_EN
            CLS_CBNZ:            state_d = ST_CBRANCH;
`else
            CLS_CBNZ:            state_d = ST_HALT;
`endif
            CLS_BR:              state_d = ST_JUMP;
            default:             state_d = ST_HALT;
          endcase
        end
        ST_MEM_ADDR: begin
          ALU_Src_A = 1'b1;
          ALU_Src_B = SRC_B_IMM;
          state_d   = (instr_class == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD: begin
          Mem_Read = 1'b1;
          IorD     = 1'b1;
          if (Mem_Ready) state_d = ST_MEM_WB;
        end
        ST_MEM_WB: begin
          Reg_Write     = 1'b1;
          Mem_to_Reg    = 1'b1;
          Instr_Retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_MEM_WR: begin
          Mem_Write     = 1'b1;
          IorD          = 1'b1;
          Reg2Loc       = 1'b1;
          Instr_Retired = Mem_Ready;
          if (Mem_Ready) state_d = ST_FETCH;
        end
        ST_R_EXEC: begin
          ALU_Src_A = 1'b1;
          ALU_Src_B = SRC_B_REG;
          alu_op    = ALU_OP_FUNCT;
          state_d   = ST_R_WB;
        end
        ST_R_WB: begin
          Reg_Write     = 1'b1;
          Instr_Retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_CBRANCH: begin
          Reg2Loc       = 1'b1;
          ALU_Src_B     = SRC_B_REG;
          alu_op        = ALU_OP_PASS_B;
          PC_Source     = 1'b1;
          PC_Write      = take_branch;
          Instr_Retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_JUMP: begin
          PC_Source     = 1'b1;
          PC_Write      = 1'b1;
          Instr_Retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_HALT: begin
          Illegal = 1'b1;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-instruction phase model.
module tb_multicycle_control;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100101;
  localparam logic [10:0] T_CBNZ = 11'b10110101011;
  localparam logic [10:0] T_B    = 11'b00010110011;
  localparam logic [10:0] T_BAD  = 11'b00000000000;

  // Output vector bit positions
  localparam int B_PCW = 15, B_IORD = 14, B_MRD = 13, B_MWR = 12, B_IRW = 11;
  localparam int B_R2L = 10, B_SRCA = 9, B_PCSRC = 4, B_M2R = 3, B_RW = 2;
  localparam int B_ILL = 1, B_RET = 0;

  // Phases of an instruction
  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_WR = 5;
  localparam int S_RE = 6, S_RW = 7, S_CB = 8, S_J = 9, S_H = 10;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CB = 3, C_B = 4, C_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic        PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Reg2Loc, ALU_Src_A;
  logic [1:0]  ALU_Src_B, ALU_Op;
  logic        PC_Source, Mem_to_Reg, Reg_Write, Illegal, Instr_Retired;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_vec = '0;
  logic        exp_valid = 1'b0;
  int          cur_idx = 0;
  int          nsteps = 0;
  logic        inv_zero = 1'b0;
  logic [15:0] obs_log [0:63];
  logic [15:0] dut_vec;
  int          ncyc;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .IorD(IorD), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .IR_Write(IR_Write), .Reg2Loc(Reg2Loc), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
    .ALU_Op(ALU_Op), .PC_Source(PC_Source), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
    .Illegal(Illegal), .Instr_Retired(Instr_Retired)
  );

  assign dut_vec = {PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Reg2Loc, ALU_Src_A,
                    ALU_Src_B, ALU_Op, PC_Source, Mem_to_Reg, Reg_Write, Illegal, Instr_Retired};

  function automatic int classify(input logic [10:0] op);
    if (op == T_ADD || op == T_SUB || op == T_AND || op == T_ORR) return C_R;
    if (op == T_LDUR) return C_LD;
    if (op == T_STUR) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CB;
`ifdef CBNZ_EN
    if (op[10:3] == 8'b10110101) return C_CB;
`endif
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [15:0] exp_out(input int step, input logic mr, input logic z,
                                          input logic inv);
    logic [15:0] v;
    v = '0;
    case (step)
      S_F:   begin v[B_MRD] = 1'b1; v[8:7] = 2'b01; v[B_IRW] = mr; v[B_PCW] = mr; end
      S_D:   v[8:7] = 2'b11;
      S_MA:  begin v[B_SRCA] = 1'b1; v[8:7] = 2'b10; end
      S_MR:  begin v[B_MRD] = 1'b1; v[B_IORD] = 1'b1; end
      S_MWB: begin v[B_RW] = 1'b1; v[B_M2R] = 1'b1; v[B_RET] = 1'b1; end
      S_WR:  begin v[B_MWR] = 1'b1; v[B_IORD] = 1'b1; v[B_R2L] = 1'b1; v[B_RET] = mr; end
      S_RE:  begin v[B_SRCA] = 1'b1; v[6:5] = 2'b10; end
      S_RW:  begin v[B_RW] = 1'b1; v[B_RET] = 1'b1; end
      S_CB:  begin
        v[B_R2L] = 1'b1; v[6:5] = 2'b01; v[B_PCSRC] = 1'b1;
        v[B_PCW] = inv ? ~z : z; v[B_RET] = 1'b1;
      end
      S_J:   begin v[B_PCSRC] = 1'b1; v[B_PCW] = 1'b1; v[B_RET] = 1'b1; end
      S_H:   v[B_ILL] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  // Single compare point against the model, mid-cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      obs_log[cur_idx] = dut_vec;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t step=%0d got %b want %b", $time, cur_idx, dut_vec, exp_vec);
      end
    end
  end

  task automatic do_cycle(input int step, input logic mr, input logic z);
    @(posedge clk);
    #1;
    Mem_Ready = mr;
    Zero      = z;
    exp_vec   = exp_out(step, mr, z, inv_zero);
    cur_idx   = nsteps;
    exp_valid = 1'b1;
    nsteps++;
  endtask

  task automatic run_instr(input logic [10:0] op, input logic z, input int fw, input int mw,
                           output int n);
    int cls;
    cls      = classify(op);
    nsteps   = 0;
    inv_zero = (op[10:3] == 8'b10110101);
    for (int i = 0; i < fw; i++) do_cycle(S_F, 1'b0, z);
    do_cycle(S_F, 1'b1, z);
    Opcode = op;
    do_cycle(S_D, 1'b1, z);
    case (cls)
      C_R:  begin do_cycle(S_RE, 1'b1, z); do_cycle(S_RW, 1'b1, z); end
      C_LD: begin
        do_cycle(S_MA, 1'b1, z);
        for (int i = 0; i < mw; i++) do_cycle(S_MR, 1'b0, z);
        do_cycle(S_MR, 1'b1, z);
        do_cycle(S_MWB, 1'b1, z);
      end
      C_ST: begin
        do_cycle(S_MA, 1'b1, z);
        for (int i = 0; i < mw; i++) do_cycle(S_WR, 1'b0, z);
        do_cycle(S_WR, 1'b1, z);
      end
      C_CB: do_cycle(S_CB, 1'b1, z);
      C_B:  do_cycle(S_J, 1'b1, z);
      default: for (int i = 0; i < 20; i++) do_cycle(S_H, logic'(i % 2), z);
    endcase
    n = nsteps;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    #1;
    rst_n   = 1'b0;
    exp_vec = '0;
    #1;
    chk({name, "_outputs_zero"}, int'(dut_vec), 0);
    repeat (2) @(posedge clk);
    #1;
    Mem_Ready = 1'b0;
    exp_vec   = exp_out(S_F, 1'b0, 1'b0, 1'b0);
    cur_idx   = 0;
    rst_n     = 1'b1;
    #1;
    chk({name, "_first_fetch"}, int'(Mem_Read), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_valid = 1'b1;
    do_reset("init");

    run_instr(T_ADD, 1'b0, 0, 0, ncyc);
    chk("add_cycles", ncyc, 4);
    chk("add_rexec_aluop", int'(obs_log[2][6:5]), 2);
    chk("add_c4_wb_ret", int'({obs_log[3][B_RW], obs_log[3][B_RET]}), 3);

    run_instr(T_SUB, 1'b1, 2, 0, ncyc);
    chk("sub_fetch_stall_cycles", ncyc, 6);
    run_instr(T_AND, 1'b0, 0, 0, ncyc);
    run_instr(T_ORR, 1'b1, 1, 0, ncyc);

    run_instr(T_LDUR, 1'b0, 0, 2, ncyc);
    chk("ldur_cycles", ncyc, 7);
    chk("ldur_wb_m2r_rw", int'({obs_log[6][B_M2R], obs_log[6][B_RW]}), 3);

    run_instr(T_STUR, 1'b0, 0, 1, ncyc);
    chk("stur_cycles", ncyc, 5);
    chk("stur_stall_no_ret", int'(obs_log[3][B_RET]), 0);

    run_instr(T_CBZ, 1'b1, 0, 0, ncyc);
    chk("cbz_taken_pcw_src", int'({obs_log[2][B_PCW], obs_log[2][B_PCSRC]}), 3);
    run_instr(T_CBZ, 1'b0, 0, 0, ncyc);
    chk("cbz_not_taken", int'({obs_log[2][B_PCW], obs_log[2][B_RET]}), 1);
    chk("cbz_cycles", ncyc, 3);

    run_instr(T_B, 1'b0, 0, 0, ncyc);
    chk("b_cycles", ncyc, 3);

`ifdef CBNZ_EN
    run_instr(T_CBNZ, 1'b0, 0, 0, ncyc);
    chk("cbnz_taken", int'(obs_log[2][B_PCW]), 1);
    run_instr(T_CBNZ, 1'b1, 0, 0, ncyc);
    chk("cbnz_not_taken", int'(obs_log[2][B_PCW]), 0);
`else
    run_instr(T_CBNZ, 1'b0, 0, 0, ncyc);
    chk("cbnz_halts", int'(obs_log[2]), 2);
    do_reset("cbnz_rst");
`endif

    run_instr(T_BAD, 1'b0, 0, 0, ncyc);
    chk("illegal_held_20", int'(obs_log[21]), 2);
    do_reset("halt_rst");
    chk("illegal_cleared", int'(Illegal), 0);

    nsteps = 0;
    do_cycle(S_F, 1'b1, 1'b0);
    Opcode = T_STUR;
    inv_zero = 1'b0;
    do_cycle(S_D, 1'b1, 1'b0);
    do_cycle(S_MA, 1'b1, 1'b0);
    do_cycle(S_WR, 1'b0, 1'b0);
    do_cycle(S_WR, 1'b0, 1'b0);
    chk("wr_active_before_rst", int'(Mem_Write), 1);
    do_reset("wr_rst");

    run_instr(T_ADD, 1'b0, 0, 0, ncyc);
    chk("add_after_rst_cycles", ncyc, 4);

    @(posedge clk);
    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
